// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register countdown of cycles until the youngest
// in-flight write reaches a bypass bus, plus stall generation and operand bypass select.
module id_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int DW   = 32,
    parameter int NSRC = 2,
    parameter int NBYP = 3,
    parameter int LW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_waddr,
    input  logic [LW-1:0]        issue_lat,
    input  logic [NSRC-1:0]      src_en,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC*DW-1:0]   rf_rdata,
    input  logic [NBYP-1:0]      byp_we,
    input  logic [NBYP*AW-1:0]   byp_waddr,
    input  logic [NBYP*DW-1:0]   byp_wdata,
    output logic [NSRC*DW-1:0]   operand,
    output logic                 stallreq,
    output logic                 issue_fire,
    output logic [NREG-1:0]      busy_mask,
    output logic [31:0]          stall_count
);

    logic [LW-1:0] cnt_q [NREG];
    logic [LW-1:0] cnt_d [NREG];
    logic [31:0]   stall_count_q;
    logic [31:0]   stall_count_d;
    logic          src_busy;

    // Any enabled source whose register still has cycles outstanding blocks issue.
    always_comb begin
        src_busy = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_en[i] && (cnt_q[src_addr[i*AW +: AW]] != '0)) begin
                src_busy = 1'b1;
            end
        end
    end

    assign stallreq   = issue_valid & src_busy;
    assign issue_fire = issue_valid & ~stallreq & ~hold & ~flush;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            // NOTE: every combinational output gets a default on each path so no latch is inferred.
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (!hold && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LW'(1);
            end
            // issue_fire already excludes flush and hold, so a new writer wins over the decrement.
            if (issue_fire && issue_we && (issue_waddr == AW'(r))) begin
                cnt_d[r] = issue_lat;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stallreq && !hold && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Youngest matching bypass stage wins; r0 reads as zero and never matches a bypass.
    always_comb begin
        logic [AW-1:0] addr;
        logic [DW-1:0] sel;
        logic          hit;
        operand = '0;
        for (int i = 0; i < NSRC; i++) begin
            addr = src_addr[i*AW +: AW];
            sel  = rf_rdata[i*DW +: DW];
            hit  = 1'b0;
            for (int j = 0; j < NBYP; j++) begin
                if (!hit && byp_we[j] && (byp_waddr[j*AW +: AW] == addr)
                    && (byp_waddr[j*AW +: AW] != '0)) begin
                    sel = byp_wdata[j*DW +: DW];
                    hit = 1'b1;
                end
            end
            if (addr == '0) begin
                sel = '0;
            end
            operand[i*DW +: DW] = sel;
        end
    end

    // NOTE: the counter array is real pending state, so it is reset like any other flop; a
    // stale count after reset would stall a freshly restarted pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample together.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
